// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, defaults and
// a small helper for index widths.
package mem_arbiter_pkg;

    // IDLE: nobody holds the memory. OWNED: one requester holds a burst lock.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int BURST_MAX_DEFAULT = 8;

    // Width needed to index n requesters. Never less than one bit.
    function automatic int arb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter.
// The slave modport is the arbiter's view of the bus.
// The master modport is the environment's view: the requesters plus the RAM macro.
interface mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               m_en;
    logic               m_we;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic [DW-1:0]      m_rdata;

    modport slave (
        input  req, lock, we, addr, wdata, m_rdata,
        output gnt, rvalid, rdata, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output req, lock, we, addr, wdata, m_rdata,
        input  gnt, rvalid, rdata, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin pick.
// The search starts just after ptr and wraps modulo N.
// Requesters set in excl are skipped.
// The result is a one-hot vector, its index, and a found flag.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_idx,
    output logic          found
);
    logic [N-1:0] elig;

    assign elig = req & ~excl;

    // Search ptr+1, ptr+2, ... and keep the first eligible requester.
    always_comb begin
        int cand;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && elig[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                pick_idx   = PW'(cand);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for one single-port synchronous RAM (1-cycle read latency).
// A grant is issued in the same cycle as the request, and rvalid follows one cycle later.
// A requester may hold a lock to keep ownership, for at most BURST_MAX consecutive grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int PW = arb_idx_width(NREQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t      state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [NREQ-1:0] rvalid_reg;

    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] excl;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic            found;
    logic            own_req;
    logic            own_lock;
    logic            burst_done;
    logic [NREQ-1:0] gnt_sel;
    logic [NREQ-1:0] gnt;

    assign owner_oh   = NREQ'(1) << owner_reg;
    assign own_req    = (state_reg == ARB_OWNED) && bus.req[owner_reg];
    assign own_lock   = bus.lock[owner_reg];
    assign burst_done = (cnt_reg >= CW'(BURST_MAX));

    // When a burst is exhausted, the owner is left out of this cycle's pick.
    // This lets another requester in.
    assign excl = (state_reg == ARB_OWNED && burst_done) ? owner_oh : '0;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req      (bus.req),
        .excl     (excl),
        .ptr      (ptr_reg),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (found)
    );

    // Grant decision and next-state computation.
    always_comb begin
        gnt_sel    = '0;
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        if (own_req && !burst_done) begin
            // The owner keeps the memory. Dropping its lock makes this the final beat.
            gnt_sel = owner_oh;
            if (own_lock) begin
                cnt_next = cnt_reg + CW'(1);
            end else begin
                state_next = ARB_IDLE;
                cnt_next   = '0;
            end
        end else if (found) begin
            // Normal rotation. This also covers an owner that released,
            // so the release costs no dead cycle.
            gnt_sel  = pick;
            ptr_next = pick_idx;
            if (bus.lock[pick_idx]) begin
                state_next = ARB_OWNED;
                owner_next = pick_idx;
                cnt_next   = CW'(1);
            end else begin
                state_next = ARB_IDLE;
                cnt_next   = '0;
            end
        end else if (own_req) begin
            // The burst is exhausted and nobody else is waiting.
            // The owner gets one more beat, but without its lock.
            gnt_sel    = owner_oh;
            ptr_next   = owner_reg;
            state_next = ARB_IDLE;
            cnt_next   = '0;
        end else begin
            state_next = ARB_IDLE;
            cnt_next   = '0;
        end
    end

    // While reset is low, nothing may reach the memory.
    assign gnt = reset ? gnt_sel : '0;

    // Arbiter state and the registered read-valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ARB_IDLE;
            ptr_reg    <= PW'(NREQ - 1);
            owner_reg  <= '0;
            cnt_reg    <= '0;
            rvalid_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
            rvalid_reg <= gnt_sel & ~bus.we;
        end
    end

    // AND-OR multiplexing of address and write data over the one-hot grant.
    logic [AW-1:0] addr_term  [NREQ];
    logic [DW-1:0] wdata_term [NREQ];
    logic [AW-1:0] m_addr_or;
    logic [DW-1:0] m_wdata_or;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
            assign addr_term[gi]  = {AW{gnt[gi]}} & bus.addr[gi*AW +: AW];
            assign wdata_term[gi] = {DW{gnt[gi]}} & bus.wdata[gi*DW +: DW];
        end
    endgenerate

    // OR-reduce the masked terms. Only the granted requester contributes.
    always_comb begin
        m_addr_or  = '0;
        m_wdata_or = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_addr_or  = m_addr_or | addr_term[i];
            m_wdata_or = m_wdata_or | wdata_term[i];
        end
    end

    assign bus.gnt     = gnt;
    assign bus.m_en    = |gnt;
    assign bus.m_we    = |(gnt & bus.we);
    assign bus.m_addr  = m_addr_or;
    assign bus.m_wdata = m_wdata_or;
    assign bus.rvalid  = rvalid_reg;
    assign bus.rdata   = bus.m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// A behavioural RAM model with 1-cycle read latency sits on the memory side.
// Inputs are driven on the falling edge.
// The combinational grant is sampled 1 time unit after the inputs are driven.
// Registered outputs are sampled on the falling edge.
module tb_mem_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    logic [DW-1:0] mem [0:1023];

    mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .BURST_MAX (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: writes complete on the edge, and read data appears after the edge.
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr[11:2]] <= bus.m_wdata;
            else          bus.m_rdata <= mem[bus.m_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rot_exp [4];
        rot_exp[0] = 3'b001; rot_exp[1] = 3'b010; rot_exp[2] = 3'b100; rot_exp[3] = 3'b001;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        bus.m_rdata = '0;
        bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b0;

        // Reset state: a request while reset is low must not be granted.
        #2;
        chk("rst_rvalid", bus.rvalid, 3'b000);
        bus.req = 3'b111;
        #1;
        chk("rst_gnt", bus.gnt, 3'b000);
        chk("rst_m_en", bus.m_en, 1'b0);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // 1. Reset asserted mid-read: the read is dropped and produces no rvalid.
        @(negedge clk);
        bus.req = 3'b010; bus.addr[1*AW +: AW] = 32'h40;
        #1;
        chk("t1_gnt_pre", bus.gnt, 3'b010);
        chk("t1_addr_pre", bus.m_addr, 32'h40);
        #1 reset = 1'b0;
        #1;
        chk("t1_gnt_in_rst", bus.gnt, 3'b000);
        chk("t1_m_en_in_rst", bus.m_en, 1'b0);
        @(negedge clk);
        chk("t1_rvalid_dropped", bus.rvalid, 3'b000);
        bus.req = '0;
        reset = 1'b1;
        bus.addr = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) chk("t1_rot_rvalid", bus.rvalid, rot_exp[k-1]);
            bus.req = 3'b111;
            #1;
            chk("t1_rot_gnt", bus.gnt, rot_exp[k]);
        end
        @(negedge clk);
        chk("t1_rot_rvalid_last", bus.rvalid, 3'b001);
        bus.req = '0;
        #1;
        chk("idle_gnt", bus.gnt, 3'b000);
        chk("idle_m_en", bus.m_en, 1'b0);
        chk("idle_m_addr", bus.m_addr, 32'h0);

        // 2. A single read by requester 1.
        @(negedge clk);
        bus.req = 3'b010; bus.we = 3'b000; bus.addr[1*AW +: AW] = 32'h100;
        #1;
        chk("t2_gnt", bus.gnt, 3'b010);
        chk("t2_m_en", bus.m_en, 1'b1);
        chk("t2_m_we", bus.m_we, 1'b0);
        chk("t2_m_addr", bus.m_addr, 32'h100);
        @(negedge clk);
        chk("t2_rvalid", bus.rvalid, 3'b010);
        chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
        bus.req = '0;
        @(negedge clk);
        chk("t2_rvalid_once", bus.rvalid, 3'b000);

        // 3. Requester 2 writes, then requester 0 reads the same word back.
        bus.req = 3'b100; bus.we = 3'b100;
        bus.addr[2*AW +: AW] = 32'h20; bus.wdata[2*DW +: DW] = 32'h55AA55AA;
        #1;
        chk("t3_wr_gnt", bus.gnt, 3'b100);
        chk("t3_wr_m_we", bus.m_we, 1'b1);
        chk("t3_wr_m_addr", bus.m_addr, 32'h20);
        chk("t3_wr_m_wdata", bus.m_wdata, 32'h55AA55AA);
        @(negedge clk);
        chk("t3_wr_no_rvalid", bus.rvalid, 3'b000);
        bus.req = 3'b001; bus.we = 3'b000; bus.addr[0 +: AW] = 32'h20;
        #1;
        chk("t3_rd_gnt", bus.gnt, 3'b001);
        chk("t3_rd_m_we", bus.m_we, 1'b0);
        @(negedge clk);
        chk("t3_rd_rvalid", bus.rvalid, 3'b001);
        chk("t3_rd_rdata", bus.rdata, 32'h55AA55AA);
        bus.req = '0;

        // 4. A locked burst by requester 2 while requester 0 waits.
        @(negedge clk);
        bus.req = 3'b100; bus.lock = 3'b100; bus.addr[2*AW +: AW] = 32'h30;
        #1;
        chk("t4_gnt_c1", bus.gnt, 3'b100);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            bus.req = 3'b101;
            #1;
            chk("t4_gnt_locked", bus.gnt, 3'b100);
        end
        @(negedge clk);
        #1;
        chk("t4_gnt_c9_forced", bus.gnt, 3'b001);
        @(negedge clk);
        #1;
        chk("t4_gnt_c10_reacq", bus.gnt, 3'b100);
        @(negedge clk);
        bus.req = '0; bus.lock = '0;
        #1;
        chk("t4_release_gnt", bus.gnt, 3'b000);

        // A lock without a request is ignored.
        @(negedge clk);
        bus.lock = 3'b111;
        #1;
        chk("lock_no_req_gnt", bus.gnt, 3'b000);
        chk("lock_no_req_m_en", bus.m_en, 1'b0);
        bus.lock = '0;

        // 5. Locked owner 1 drops its request while requester 0 is pending.
        @(negedge clk);
        bus.req = 3'b010; bus.lock = 3'b010;
        #1;
        chk("t5_gnt_c1", bus.gnt, 3'b010);
        @(negedge clk);
        bus.req = 3'b011;
        #1;
        chk("t5_gnt_c2_hold", bus.gnt, 3'b010);
        @(negedge clk);
        bus.req = 3'b001; bus.lock = 3'b000;
        #1;
        chk("t5_gnt_c3_handover", bus.gnt, 3'b001);

        // 6. Requester 0 holds a lock alone: the grant never gaps.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.req = 3'b001; bus.lock = 3'b001;
            #1;
            chk("t6_gnt_solo", bus.gnt, 3'b001);
        end
        @(negedge clk);
        bus.req = '0; bus.lock = '0;
        #1;
        chk("t6_release_gnt", bus.gnt, 3'b000);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
